// File: rtl/snn_feeder_pkg.sv
// ============================================================================
//  Module   : snn_feed_pkg
//  Purpose  : Shared constants, config-select encodings and FSM states for the
//             SNN stimulus feeder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package snn_feed_pkg;

    localparam int IMG_SIDE = 6;
    localparam int IMG_LEN  = 2 * IMG_SIDE * IMG_SIDE;
    localparam int KER_LEN  = 9;
    localparam int WGT_LEN  = 4;
    localparam int RES_W    = 10;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 7;

    typedef enum logic [1:0] {
        SEL_IMG  = 2'd0,
        SEL_KER  = 2'd1,
        SEL_WGT  = 2'd2,
        SEL_NONE = 2'd3
    } cfg_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/snn_feeder_if.sv
// ============================================================================
//  Module   : snn_feeder_if
//  Purpose  : Link between the feeder (master) and the SNN core (slave).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface snn_feeder_if;
    import snn_feed_pkg::*;

    logic                snn_in_valid;
    logic [DATA_W-1:0]   snn_img;
    logic [DATA_W-1:0]   snn_ker;
    logic [DATA_W-1:0]   snn_weight;
    logic                snn_out_valid;
    logic [RES_W-1:0]    snn_out_data;

    modport master (
        output snn_in_valid, snn_img, snn_ker, snn_weight,
        input  snn_out_valid, snn_out_data
    );

    modport slave (
        input  snn_in_valid, snn_img, snn_ker, snn_weight,
        output snn_out_valid, snn_out_data
    );

endinterface

`default_nettype wire

// File: rtl/snn_frame_store.sv
// ============================================================================
//  Module   : snn_frame_store
//  Purpose  : Image/kernel/weight register file with range-checked writes and
//             a beat-indexed read mux.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module snn_frame_store
    import snn_feed_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we_i,
    input  wire logic [1:0]        sel_i,
    input  wire logic [CNT_W-1:0]  addr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic [CNT_W-1:0]  rd_idx_i,
    output logic      [DATA_W-1:0] img_o,
    output logic      [DATA_W-1:0] ker_o,
    output logic      [DATA_W-1:0] wgt_o
);

    logic [DATA_W-1:0] img_q [IMG_LEN];
    logic [DATA_W-1:0] ker_q [KER_LEN];
    logic [DATA_W-1:0] wgt_q [WGT_LEN];

    logic img_we;
    logic ker_we;
    logic wgt_we;

    always_comb begin
        img_we = we_i && (sel_i == SEL_IMG) && (addr_i < CNT_W'(IMG_LEN));
        ker_we = we_i && (sel_i == SEL_KER) && (addr_i < CNT_W'(KER_LEN));
        wgt_we = we_i && (sel_i == SEL_WGT) && (addr_i < CNT_W'(WGT_LEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMG_LEN; i++) img_q[i] <= '0;
            for (int i = 0; i < KER_LEN; i++) ker_q[i] <= '0;
            for (int i = 0; i < WGT_LEN; i++) wgt_q[i] <= '0;
        end else begin
            if (img_we) img_q[addr_i]      <= wdata_i;
            if (ker_we) ker_q[addr_i[3:0]] <= wdata_i;
            if (wgt_we) wgt_q[addr_i[1:0]] <= wdata_i;
        end
    end

    // Kernel and weight only occupy the first beats of the burst; later beats read 0.
    always_comb begin
        img_o = (rd_idx_i < CNT_W'(IMG_LEN)) ? img_q[rd_idx_i]      : '0;
        ker_o = (rd_idx_i < CNT_W'(KER_LEN)) ? ker_q[rd_idx_i[3:0]] : '0;
        wgt_o = (rd_idx_i < CNT_W'(WGT_LEN)) ? wgt_q[rd_idx_i[1:0]] : '0;
    end

endmodule

`default_nettype wire

// File: rtl/snn_feeder.sv
// ============================================================================
//  Module   : snn_feeder
//  Purpose  : Streams one stored frame to the SNN core as a 72-beat burst and
//             captures the 10-bit response. Optional wait timeout is enabled
//             with the SNN_FEED_TIMEOUT_EN macro.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module snn_feeder
    import snn_feed_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              cfg_we,
    input  wire logic [1:0]        cfg_sel,
    input  wire logic [CNT_W-1:0]  cfg_addr,
    input  wire logic [DATA_W-1:0] cfg_wdata,
    input  wire logic              start,
    output logic                   busy,
    output logic                   done,
    output logic      [RES_W-1:0]  result,
    output logic                   timeout,
    snn_feeder_if.master           snn
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, done_q, in_valid_q;
    logic [DATA_W-1:0] img_q, ker_q, wgt_q;
    logic [DATA_W-1:0] rd_img, rd_ker, rd_wgt;

`ifdef SNN_FEED_TIMEOUT_EN
    localparam int WCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              expired;
    assign expired = (wcnt_q == WCNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

    // Read side follows the next beat index so the registered outputs line up with it.
    snn_frame_store u_store (
        .clk      (clk),
        .rst      (rst),
        .we_i     (cfg_we && !busy_q),
        .sel_i    (cfg_sel),
        .addr_i   (cfg_addr),
        .wdata_i  (cfg_wdata),
        .rd_idx_i (cnt_d),
        .img_o    (rd_img),
        .ker_o    (rd_ker),
        .wgt_o    (rd_wgt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;
`ifdef SNN_FEED_TIMEOUT_EN
        wcnt_d    = wcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (cnt_q == CNT_W'(IMG_LEN - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
`ifdef SNN_FEED_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (snn.snn_out_valid) begin
                    result_d  = snn.snn_out_data;
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end
`ifdef SNN_FEED_TIMEOUT_EN
                else if (expired) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_valid_q <= 1'b0;
            img_q      <= '0;
            ker_q      <= '0;
            wgt_q      <= '0;
`ifdef SNN_FEED_TIMEOUT_EN
            wcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            in_valid_q <= (state_d == SEND);
            img_q      <= (state_d == SEND) ? rd_img : '0;
            ker_q      <= (state_d == SEND) ? rd_ker : '0;
            wgt_q      <= (state_d == SEND) ? rd_wgt : '0;
`ifdef SNN_FEED_TIMEOUT_EN
            wcnt_q     <= wcnt_d;
`endif
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign result           = result_q;
    assign timeout          = timeout_q;
    assign snn.snn_in_valid = in_valid_q;
    assign snn.snn_img      = img_q;
    assign snn.snn_ker      = ker_q;
    assign snn.snn_weight   = wgt_q;

endmodule

`default_nettype wire

// File: doc/snn_feeder.md
# snn_feeder

Stimulus transmitter for the SNN accelerator's input protocol. It holds one frame (two 6x6 images, a 3x3 kernel and a 2x2 weight matrix) in a local register file, loaded through a byte-wide config port. On `start` it streams the frame as a 72-cycle `in_valid` burst in SNN order, then waits for the SNN's single-cycle `out_valid` and captures the 10-bit result. It sits between the test or host controller and the SNN core.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: maximum number of WAIT cycles. Only used with `SNN_FEED_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cfg_we` in 1: config write strobe.
- `cfg_sel` in 2: write target; 0 = image, 1 = kernel, 2 = weight, 3 = none.
- `cfg_addr` in 7: byte address within the selected target.
- `cfg_wdata` in 8: write data.
- `start` in 1: begin one frame transfer.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `result` out 10: last captured `out_data`.
- `timeout` out 1: last transfer ended without a response.
- `snn_in_valid` out 1: driven to the SNN's `in_valid`.
- `snn_img` out 8: driven to the SNN's `img`.
- `snn_ker` out 8: driven to the SNN's `ker`.
- `snn_weight` out 8: driven to the SNN's `weight`.
- `snn_out_valid` in 1: from the SNN's `out_valid`.
- `snn_out_data` in 10: from the SNN's `out_data`.

## Operation
Storage layout:
- Image memory is 72 bytes. Image 0 occupies addresses 0–35 and image 1 occupies 36–71, both row-major (address = row*6 + col, + 36 for image 1).
- Kernel memory is 9 bytes, row-major (address = row*3 + col).
- Weight memory is 4 bytes, address = row*2 + col.

Config writes:
- Ignored when `busy` = 1.
- Ignored when `cfg_sel` = 3.
- Ignored when the address is out of range: image > 71, kernel > 8, weight > 3.

State machine:
- IDLE: on `start`, go to SEND and clear the beat counter.
- SEND: 72 beats, with the counter running 0..71.
  - `snn_img` = img[cnt].
  - `snn_ker` = ker[cnt] when cnt < 9, else 0.
  - `snn_weight` = wgt[cnt] when cnt < 4, else 0.
  - After cnt = 71, go to WAIT.
- WAIT: on `snn_out_valid`, load `result` from `snn_out_data`, clear `timeout`, go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.

Other rules:
- `start` is ignored outside IDLE.
- `snn_out_valid` is ignored outside WAIT.
- `busy` = 1 in SEND, WAIT and DONE.
- All `snn_*` outputs are 0 whenever not in SEND.

Reset (`rst` = 1 at a rising edge):
- State returns to IDLE and all counters clear.
- All three memories clear to 0.
- Every output is 0: `busy`, `done`, `result`, `timeout`, `snn_in_valid`, `snn_img`, `snn_ker`, `snn_weight`.
- Reset asserted mid-SEND or mid-WAIT aborts the transfer at that edge and no `done` is produced.

## Timing
- All outputs are registered.
- `start` sampled high at edge t in IDLE → `snn_in_valid` and `busy` high from cycle t+1; `snn_in_valid` stays high through t+72 (exactly 72 contiguous cycles), with beat k presented in cycle t+1+k.
- WAIT is entered at cycle t+73.
- `snn_out_valid` sampled high at edge u in WAIT → `result` updated and `done` = 1 in cycle u+1; `busy` falls in cycle u+2.
- Back-to-back transfers: the earliest accepted `start` is the cycle after `done`.

## Configuration
- `SNN_FEED_TIMEOUT_EN` defined:
  - A wait counter clears on WAIT entry and increments every WAIT cycle.
  - If the counter equals `TIMEOUT_CYC`-1 and `snn_out_valid` = 0, the next state is DONE with `timeout` = 1 and `result` = 0.
  - `snn_out_valid` in the expiry cycle wins: normal capture, `timeout` = 0.
- Not defined: WAIT lasts indefinitely, and `timeout` is constant 0.

## Structure
- Package `snn_feed_pkg` holds:
  - constants IMG_LEN = 72, IMG_SIDE = 6, KER_LEN = 9, WGT_LEN = 4, RES_W = 10;
  - the `cfg_sel` encodings;
  - the state enum (IDLE, SEND, WAIT, DONE).
- One sub-module, `snn_frame_store`, contains the three memories, the write decode with range checks, and the read mux indexed by beat count.
- The FSM, counters and output registers stay in `snn_feeder`.

## Test plan
- Stream order: load img[i] = i, ker all 1, wgt = 1, 2, 3, 4; `start` → 72 `snn_in_valid` beats with `snn_img` = 0..71, `snn_ker` = 1 for beats 0–8 then 0, `snn_weight` = 1, 2, 3, 4 then 0.
- Capture: the responder model asserts `snn_out_valid` with 10'd37 100 cycles into WAIT → `result` = 37 and a single-cycle `done` pulse one cycle later; `busy` low the cycle after that.
- Ignored inputs while busy: `start` pulse and `cfg_we` writing img[0] = 0xFF during SEND → stream unchanged, img[0] still 0 on the next transfer.
- Out-of-range write: `cfg_sel` = 1, `cfg_addr` = 9 → no memory changes.
- Timeout (macro on, `TIMEOUT_CYC` = 20), no response → `done` = 1 and `timeout` = 1 exactly 20 cycles after WAIT entry, `result` = 0. Macro off → still waiting after 1000 cycles.
- Reset: `rst` asserted at beat 30 → next cycle `snn_in_valid` = 0 and `busy` = 0, memories read back 0, no `done` pulse.
